// File: rtl/edge_detc_array.sv
// Multi-channel synchronising edge detector with sticky W1C pending flags and one masked irq.
// Optional debounce filter is enabled by defining EDGE_DETC_DEBOUNCE_EN.
module edge_detc_array #(
   parameter int   N           = 4,
   parameter int   SYNC_STAGES = 2,
   parameter int   DB_CYCLES   = 4,
   parameter int   DB_W        = 3,
   parameter logic RESET_LEVEL = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   signal,
   input  logic [2*N-1:0] mode,
   input  logic [N-1:0]   irq_mask,
   input  logic [N-1:0]   clr,
   output logic [N-1:0]   level,
   output logic [N-1:0]   pulse,
   output logic [N-1:0]   pending,
   output logic           irq
);

   if (N < 1 || N > 32 || SYNC_STAGES < 2 || DB_CYCLES < 1 || DB_W < 1) begin : g_bad_params
      $error("edge_detc_array: illegal parameter combination");
   end

   function automatic logic [N-1:0] edge_pulse(input logic [N-1:0]   level_old,
                                               input logic [N-1:0]   level_new,
                                               input logic [2*N-1:0] mode_sel);
      logic [N-1:0] result;
      result = '0;
      for (int i = 0; i < N; i++) begin
         result[i] = (~level_old[i] &  level_new[i] & mode_sel[2*i])
                   | ( level_old[i] & ~level_new[i] & mode_sel[2*i+1]);
      end
      return result;
   endfunction

   logic [N-1:0] sync_p [SYNC_STAGES];
   logic [N-1:0] sync_last;
   logic [N-1:0] level_next;
   logic [N-1:0] pulse_next;
   logic [N-1:0] pending_next;

   // Synchroniser chain: stage 0 samples the raw asynchronous inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_p[s] <= {N{RESET_LEVEL}};
         end
      end else begin
         sync_p[0] <= signal;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_p[s] <= sync_p[s-1];
         end
      end
   end

   assign sync_last = sync_p[SYNC_STAGES-1];

`ifdef EDGE_DETC_DEBOUNCE_EN
   if ((DB_CYCLES - 1) >= (1 << DB_W)) begin : g_bad_db_w
      $error("edge_detc_array: DB_W too narrow for DB_CYCLES");
   end

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic [DB_W-1:0] db_cnt [N];

   // Count consecutive cycles the synchronised input disagrees with the accepted level.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (sync_last[i] == level[i] || db_cnt[i] == DB_LAST) begin
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   always_comb begin
      level_next = level;
      for (int i = 0; i < N; i++) begin
         if (sync_last[i] != level[i] && db_cnt[i] == DB_LAST) begin
            level_next[i] = sync_last[i];
         end
      end
   end
`else
   assign level_next = sync_last;
`endif

   assign pulse_next   = edge_pulse(level, level_next, mode);
   // A new edge wins over a clear strobe arriving in the same cycle.
   assign pending_next = (pending & ~clr) | pulse_next;

   // Output stage: irq is registered from the pending register, one cycle behind it.
   always_ff @(posedge clk) begin
      if (reset) begin
         level   <= {N{RESET_LEVEL}};
         pulse   <= '0;
         pending <= '0;
         irq     <= 1'b0;
      end else begin
         level   <= level_next;
         pulse   <= pulse_next;
         pending <= pending_next;
         irq     <= |(pending & irq_mask);
      end
   end

endmodule
